// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR oversampling averager.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      CHK  = 2'd3
   } sar_state_e;

   localparam int unsigned DefWidth         = 6;
   localparam int unsigned DefLog2Avg       = 2;
   localparam int unsigned DefTimeoutCycles = 32;

   // Accumulator holds 2**log2avg codes of w bits without overflow.
   function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2avg);
      return w + log2avg;
   endfunction

   function automatic int unsigned tcnt_width(input int unsigned timeout_cycles);
      return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
   endfunction

endpackage

// File: rtl/sar_oversample_avg_edge.sv
// Registered rising-edge detector; rise_o is high in the first cycle sig_i is seen high.
module sar_edge_rise (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/sar_oversample_avg.sv
// Sequences a SAR converter, averages 2**Log2Avg results per output and flags stalled conversions.
module sar_oversample_avg
   import sar_pkg::*;
#(
   parameter int unsigned Width         = DefWidth,
   parameter int unsigned Log2Avg       = DefLog2Avg,
   parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   output logic             start_o,
   input  logic             eoc_i,
   input  logic [Width-1:0] result_i,
   output logic [Width-1:0] avg_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             timeout_o
);

   localparam int unsigned AccW  = acc_width(Width, Log2Avg);
   localparam int unsigned TcntW = tcnt_width(TimeoutCycles);
   localparam int unsigned CntW  = Log2Avg + 1;

   localparam logic [CntW-1:0]  BatchN   = CntW'(2 ** Log2Avg);
   localparam logic [TcntW-1:0] TcntLast = TcntW'(TimeoutCycles - 1);

   sar_state_e       state_q;
   logic [AccW-1:0]  acc_q;
   logic [CntW-1:0]  cnt_q;
   logic [TcntW-1:0] tcnt_q;
   logic [Width-1:0] avg_q;
   logic             valid_q;
   logic             timeout_q;

   logic             eoc_rise;
   logic [AccW-1:0]  acc_d;
   logic [CntW-1:0]  cnt_d;
   logic [Width-1:0] avg_d;

   sar_edge_rise u_eoc_rise (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sig_i  (eoc_i),
      .rise_o (eoc_rise)
   );

   assign acc_d = acc_q + AccW'(result_i);
   assign cnt_d = cnt_q + CntW'(1);
   assign avg_d = Width'(acc_d >> Log2Avg);

   // The average is registered together with the final capture so valid_o and
   // the new avg_o appear in the CHK cycle, one cycle after the last eoc edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         avg_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable_i) begin
                  state_q   <= REQ;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
               end
            end
            REQ: begin
               tcnt_q <= '0;
               if (enable_i) begin
                  state_q <= WAIT;
               end else begin
                  state_q <= IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            WAIT: begin
               if (!enable_i) begin
                  state_q <= IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end else if (eoc_rise) begin
                  acc_q   <= acc_d;
                  cnt_q   <= cnt_d;
                  state_q <= CHK;
                  if (cnt_d == BatchN) begin
                     avg_q   <= avg_d;
                     valid_q <= 1'b1;
                  end
               end else if (tcnt_q == TcntLast) begin
                  timeout_q <= 1'b1;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
               end else begin
                  tcnt_q <= tcnt_q + TcntW'(1);
               end
            end
            CHK: begin
               if (cnt_q == BatchN) begin
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= enable_i ? REQ : IDLE;
               end else begin
                  state_q <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign start_o   = (state_q == REQ);
   assign busy_o    = (state_q != IDLE);
   assign avg_o     = avg_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sar_oversample_avg.sv
// Directed bench for sar_oversample_avg: SAR responder, per-cycle reference model and literal checks.
module tb_sar_oversample_avg;

   localparam int W = 6;
   localparam int L = 2;
   localparam int T = 32;
   localparam int N = 1 << L;

   localparam int P_IDLE   = 0;
   localparam int P_PULSE  = 1;
   localparam int P_AWAIT  = 2;
   localparam int P_SETTLE = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b0;
   logic         eoc = 1'b0;
   logic [W-1:0] res = '0;
   logic         start, valid, busy, tmo;
   logic [W-1:0] avg;

   logic         en2  = 1'b0;
   logic         eoc2 = 1'b0;
   logic [W-1:0] res2 = '0;
   logic         start2, valid2, busy2, tmo2;
   logic [W-1:0] avg2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sar_oversample_avg #(.Width(W), .Log2Avg(L), .TimeoutCycles(T)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .start_o(start), .eoc_i(eoc),
      .result_i(res), .avg_o(avg), .valid_o(valid), .busy_o(busy), .timeout_o(tmo)
   );

   sar_oversample_avg #(.Width(W), .Log2Avg(0), .TimeoutCycles(T)) dut0 (
      .clk_i(clk), .rst_i(rst), .enable_i(en2), .start_o(start2), .eoc_i(eoc2),
      .result_i(res2), .avg_o(avg2), .valid_o(valid2), .busy_o(busy2), .timeout_o(tmo2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // SAR responder: each start_o takes the next {delay, value}; delay 0 = never answers.
   typedef struct { int dly; int val; } conv_t;
   conv_t convq[$];
   conv_t rc;
   int r_dly = 0, r_hold = 0, r_val = 0;

   task automatic push_conv(input int d, input int v);
      conv_t c;
      c.dly = d;
      c.val = v;
      convq.push_back(c);
   endtask

   initial forever begin
      @(negedge clk);
      if (r_hold > 0) begin
         r_hold--;
         if (r_hold == 0) eoc = 1'b0;
      end
      if (r_dly > 0) begin
         r_dly--;
         if (r_dly == 0) begin
            res    = W'(r_val);
            eoc    = 1'b1;
            r_hold = 2;
         end
      end
      if (start === 1'b1 && convq.size() > 0) begin
         rc    = convq.pop_front();
         r_dly = rc.dly;
         r_val = rc.val;
      end
   end

   // Reference model: collects samples in a queue and averages by integer division.
   int  m_phase = P_IDLE;
   int  m_smp[$];
   int  m_age = 0;
   int  m_avg = 0;
   int  m_sum;
   bit  m_prev = 1'b0, m_valid = 1'b0, m_tmo = 1'b0, m_rise;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_phase = P_IDLE; m_smp.delete(); m_age = 0; m_avg = 0;
         m_prev = 1'b0; m_valid = 1'b0; m_tmo = 1'b0;
      end else begin
         m_rise  = eoc && !m_prev;
         m_prev  = eoc;
         m_valid = 1'b0;
         case (m_phase)
            P_IDLE:
               if (en) begin m_phase = P_PULSE; m_smp.delete(); m_tmo = 1'b0; end
            P_PULSE:
               if (en) begin m_phase = P_AWAIT; m_age = 0; end
               else begin m_phase = P_IDLE; m_smp.delete(); end
            P_AWAIT:
               if (!en) begin
                  m_phase = P_IDLE; m_smp.delete();
               end else if (m_rise) begin
                  m_smp.push_back(int'(res));
                  if (m_smp.size() == N) begin
                     m_sum = 0;
                     foreach (m_smp[i]) m_sum += m_smp[i];
                     m_avg   = m_sum / N;
                     m_valid = 1'b1;
                  end
                  m_phase = P_SETTLE;
               end else if (m_age == T - 1) begin
                  m_tmo = 1'b1; m_smp.delete(); m_phase = P_IDLE;
               end else begin
                  m_age++;
               end
            default:
               if (m_smp.size() == N) begin
                  m_smp.delete();
                  m_phase = en ? P_PULSE : P_IDLE;
               end else begin
                  m_phase = P_PULSE;
               end
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      check("start_o", start, int'(m_phase == P_PULSE));
      check("busy_o",  busy,  int'(m_phase != P_IDLE));
      check("valid_o", valid, m_valid);
      check("avg_o",   avg,   m_avg);
      check("timeout_o", tmo, m_tmo);
   end

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (start) begin ok = 1'b1; break; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit ok;
      int k, nv, ns;

      repeat (3) @(negedge clk);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_avg", avg, 0);
      check("rst_timeout", tmo, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic four-sample average
      push_conv(3, 10); push_conv(2, 11); push_conv(4, 12); push_conv(1, 13);
      en = 1'b1;
      wait_valid(200, ok);
      check("t1_valid_seen", ok, 1);
      check("t1_avg", avg, 11);
      check("t1_model_avg", m_avg, 11);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // full-scale and zero batches back to back
      for (int i = 0; i < 4; i++) push_conv(2, 63);
      for (int i = 0; i < 4; i++) push_conv(3, 0);
      en = 1'b1;
      wait_valid(200, ok);
      check("t2_valid63_seen", ok, 1);
      check("t2_avg63", avg, 63);
      check("t2_model_avg63", m_avg, 63);
      wait_valid(200, ok);
      check("t2_valid0_seen", ok, 1);
      check("t2_avg0", avg, 0);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // stalled conversion times out after 32 WAIT cycles
      en = 1'b1;
      wait_start(10, ok);
      check("t3_start_seen", ok, 1);
      k = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         k++;
         if (tmo) break;
      end
      check("t3_timeout_delay", k, 33);
      check("t3_busy", busy, 0);
      check("t3_model_timeout", m_tmo, 1);
      en = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_sticky", tmo, 1);
      for (int i = 0; i < 4; i++) push_conv(1, 20);
      en = 1'b1;
      repeat (2) @(negedge clk);
      check("t3_cleared", tmo, 0);
      wait_valid(200, ok);
      check("t3_resume_valid", ok, 1);
      check("t3_resume_avg", avg, 20);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // eoc edge in the last allowed WAIT cycle is captured, not timed out
      push_conv(32, 50); push_conv(1, 50); push_conv(1, 50); push_conv(1, 50);
      en = 1'b1;
      wait_valid(300, ok);
      check("t3b_valid_seen", ok, 1);
      check("t3b_avg", avg, 50);
      check("t3b_timeout", tmo, 0);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // enable dropped after two samples: partial sum must be discarded
      push_conv(2, 40); push_conv(2, 40); push_conv(2, 63);
      for (int i = 0; i < 4; i++) push_conv(2, 8);
      en = 1'b1;
      ns = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (start) ns++;
         if (ns == 3) break;
      end
      check("t4_third_start", ns, 3);
      en = 1'b0;
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (valid) nv++;
      end
      check("t4_no_valid", nv, 0);
      check("t4_avg_held", avg, 50);
      check("t4_idle", busy, 0);
      en = 1'b1;
      wait_valid(200, ok);
      check("t4_restart_valid", ok, 1);
      check("t4_fresh_avg", avg, 8);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // asynchronous reset in the middle of WAIT
      push_conv(20, 5);
      en = 1'b1;
      wait_start(10, ok);
      check("t5_start_seen", ok, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_busy", busy, 0);
      check("t5_start", start, 0);
      check("t5_valid", valid, 0);
      check("t5_avg", avg, 0);
      check("t5_timeout", tmo, 0);
      ns = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (start) ns++;
      end
      en = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (start) ns++;
      end
      check("t5_no_start", ns, 0);
      for (int i = 0; i < 4; i++) push_conv(1, 7);
      en = 1'b1;
      wait_valid(200, ok);
      check("t5_resume_valid", ok, 1);
      check("t5_resume_avg", avg, 7);
      en = 1'b0;
      repeat (5) @(negedge clk);

      // single-sample build: passthrough, level-high eoc counts once
      en2 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (start2) begin ok = 1'b1; break; end
      end
      check("t6_start_seen", ok, 1);
      @(negedge clk);
      res2 = W'(37);
      eoc2 = 1'b1;
      @(negedge clk);
      check("t6_valid_next", valid2, 1);
      check("t6_avg", avg2, 37);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) eoc2 = 1'b0;
         if (valid2) nv++;
      end
      check("t6_single_valid", nv, 0);
      check("t6_avg_held", avg2, 37);
      en2 = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
